// File: rtl/dallanma_ongorucu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dallanma_ongorucu_pkg
//  Description : Shared definitions for the branch unit and the gshare/BTB
//                predictor: branch opcodes, counter constants, BTB entry
//                field layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package dallanma_ongorucu_pkg;

    // Conditional branch funct3 encodings used by the branch unit
    typedef enum logic [2:0] {
        DAL_BEQ  = 3'b000,
        DAL_BNE  = 3'b001,
        DAL_BLT  = 3'b100,
        DAL_BGE  = 3'b101,
        DAL_BLTU = 3'b110,
        DAL_BGEU = 3'b111
    } dal_islem_e;

    // Default saturating counter width
    localparam int c_SAYAC_BIT_VARSAYILAN = 2;

    // Counter reset value: weakly not-taken (01 for two-bit counters)
    function automatic int sayac_sifir_degeri(input int sayac_bit);
        return (1 << (sayac_bit - 1)) - 1;
    endfunction

    // BTB entry layout, LSB first: {gecerli, etiket, hedef, kosulsuz}
    localparam int c_BTB_KOSULSUZ_KONUM = 0;
    localparam int c_BTB_HEDEF_LSB      = 1;

    function automatic int btb_etiket_bit(input int ps_bit, input int satir);
        return ps_bit - $clog2(satir) - 1;
    endfunction

    function automatic int btb_etiket_lsb(input int ps_bit);
        return c_BTB_HEDEF_LSB + ps_bit;
    endfunction

    function automatic int btb_gecerli_konum(input int ps_bit, input int satir);
        return btb_etiket_lsb(ps_bit) + btb_etiket_bit(ps_bit, satir);
    endfunction

    function automatic int btb_giris_bit(input int ps_bit, input int satir);
        return btb_gecerli_konum(ps_bit, satir) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dal_hedef_tablosu.sv
`default_nettype none
// ============================================================================
//  Module      : dal_hedef_tablosu
//  Description : Direct-mapped branch target buffer. Combinational lookup
//                (tag compare) and a single synchronous write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module dal_hedef_tablosu
    import dallanma_ongorucu_pkg::*;
#(
    parameter int PS_BIT    = 32,
    parameter int BTB_SATIR = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PS_BIT-1:0] okuma_ps_i,
    output logic              isabet_o,
    output logic [PS_BIT-1:0] hedef_o,
    output logic              kosulsuz_o,
    input  logic              yaz_i,
    input  logic [PS_BIT-1:0] yaz_ps_i,
    input  logic [PS_BIT-1:0] yaz_hedef_i,
    input  logic              yaz_kosulsuz_i
);

    localparam int c_IDX_BIT    = $clog2(BTB_SATIR);
    localparam int c_ETIKET_BIT = btb_etiket_bit(PS_BIT, BTB_SATIR);
    localparam int c_ETIKET_LSB = btb_etiket_lsb(PS_BIT);
    localparam int c_GECERLI_K  = btb_gecerli_konum(PS_BIT, BTB_SATIR);
    localparam int c_GIRIS_BIT  = btb_giris_bit(PS_BIT, BTB_SATIR);

    logic [c_GIRIS_BIT-1:0]  tablo_q [BTB_SATIR];

    logic [c_IDX_BIT-1:0]    w_okuma_idx;
    logic [c_IDX_BIT-1:0]    w_yaz_idx;
    logic [c_ETIKET_BIT-1:0] w_okuma_etiket;
    logic [c_ETIKET_BIT-1:0] w_yaz_etiket;
    logic [c_GIRIS_BIT-1:0]  w_okuma_giris;
    logic [c_GIRIS_BIT-1:0]  w_yaz_giris;
    logic                    w_unused_bitler;

    // Bit 0 is always zero for RISC-V PCs; bit 1 stays in the index for RVC
    assign w_okuma_idx    = okuma_ps_i[c_IDX_BIT:1];
    assign w_okuma_etiket = okuma_ps_i[PS_BIT-1:c_IDX_BIT+1];
    assign w_yaz_idx      = yaz_ps_i[c_IDX_BIT:1];
    assign w_yaz_etiket   = yaz_ps_i[PS_BIT-1:c_IDX_BIT+1];
    assign w_unused_bitler = okuma_ps_i[0] ^ yaz_ps_i[0];

    // Lookup reads the stored value, so a same-cycle write is seen next cycle
    assign w_okuma_giris = tablo_q[w_okuma_idx];
    assign isabet_o      = w_okuma_giris[c_GECERLI_K] &&
                           (w_okuma_giris[c_GECERLI_K-1:c_ETIKET_LSB] == w_okuma_etiket);
    assign hedef_o       = w_okuma_giris[c_ETIKET_LSB-1:c_BTB_HEDEF_LSB];
    assign kosulsuz_o    = w_okuma_giris[c_BTB_KOSULSUZ_KONUM];

    assign w_yaz_giris = {1'b1, w_yaz_etiket, yaz_hedef_i, yaz_kosulsuz_i};

    // Entry storage: cleared on reset, allocated/overwritten on write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_SATIR; i++) begin
                tablo_q[i] <= '0;
            end
        end else if (yaz_i) begin
            tablo_q[w_yaz_idx] <= w_yaz_giris;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dallanma_ongorucu.sv
`default_nettype none
// ============================================================================
//  Module      : dallanma_ongorucu
//  Description : gshare direction predictor plus BTB at fetch stage G1.
//                Speculative global history with recovery from the committed
//                history on misprediction; trained from G2 resolution.
//  Revision    : 1.0 - initial release
// ============================================================================
module dallanma_ongorucu
    import dallanma_ongorucu_pkg::*;
#(
    parameter int PS_BIT     = 32,
    parameter int BTB_SATIR  = 16,
    parameter int GECMIS_BIT = 4,
    parameter int SAYAC_BIT  = c_SAYAC_BIT_VARSAYILAN
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PS_BIT-1:0] g1_ps_i,
    input  logic              g1_ps_gecerli_i,
    output logic              g1_tahmin_gecerli_o,
    output logic              g1_tahmin_atladi_o,
    output logic [PS_BIT-1:0] g1_tahmin_ps_o,
    input  logic [PS_BIT-1:0] g2_ps_i,
    input  logic [PS_BIT-1:0] g2_hedef_ps_i,
    input  logic              g2_guncelle_i,
    input  logic              g2_atladi_i,
    input  logic              g2_kosulsuz_i,
    input  logic              g2_hatali_tahmin_i
);

    localparam int                   c_PHT_SATIR   = 1 << GECMIS_BIT;
    localparam logic [SAYAC_BIT-1:0] c_SAYAC_SIFIR = SAYAC_BIT'(sayac_sifir_degeri(SAYAC_BIT));
    localparam logic [SAYAC_BIT-1:0] c_SAYAC_UST   = {SAYAC_BIT{1'b1}};

    logic [SAYAC_BIT-1:0]  pht_q [c_PHT_SATIR];
    logic [GECMIS_BIT-1:0] spec_ghr_q, spec_ghr_d;
    logic [GECMIS_BIT-1:0] komit_ghr_q, komit_ghr_d;
    logic                  tahmin_gecerli_q, tahmin_gecerli_d;
    logic                  tahmin_atladi_q, tahmin_atladi_d;
    logic [PS_BIT-1:0]     tahmin_ps_q, tahmin_ps_d;

    logic [GECMIS_BIT-1:0] w_okuma_idx;
    logic [GECMIS_BIT-1:0] w_yaz_idx;
    logic [SAYAC_BIT-1:0]  w_okunan_sayac;
    logic [SAYAC_BIT-1:0]  w_yazilan_sayac;
    logic [SAYAC_BIT-1:0]  w_sayac_yeni;
    logic                  w_btb_isabet;
    logic                  w_btb_kosulsuz;
    logic [PS_BIT-1:0]     w_btb_hedef;
    logic                  w_kurtarma;
    logic                  w_istek;
    logic                  w_yon;
    logic                  w_tahmin_atladi;
    logic                  w_kosullu_egitim;

    dal_hedef_tablosu #(
        .PS_BIT    (PS_BIT),
        .BTB_SATIR (BTB_SATIR)
    ) u_btb (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .okuma_ps_i     (g1_ps_i),
        .isabet_o       (w_btb_isabet),
        .hedef_o        (w_btb_hedef),
        .kosulsuz_o     (w_btb_kosulsuz),
        .yaz_i          (g2_guncelle_i && g2_atladi_i),
        .yaz_ps_i       (g2_ps_i),
        .yaz_hedef_i    (g2_hedef_ps_i),
        .yaz_kosulsuz_i (g2_kosulsuz_i)
    );

    // A misprediction only counts when it accompanies a resolved branch
    assign w_kurtarma       = g2_guncelle_i && g2_hatali_tahmin_i;
    assign w_istek          = g1_ps_gecerli_i && !w_kurtarma;
    assign w_kosullu_egitim = g2_guncelle_i && !g2_kosulsuz_i;

    assign w_okuma_idx     = g1_ps_i[GECMIS_BIT:1] ^ spec_ghr_q;
    assign w_yaz_idx       = g2_ps_i[GECMIS_BIT:1] ^ komit_ghr_q;
    assign w_okunan_sayac  = pht_q[w_okuma_idx];
    assign w_yazilan_sayac = pht_q[w_yaz_idx];
    assign w_yon           = w_okunan_sayac[SAYAC_BIT-1];
    assign w_tahmin_atladi = w_btb_isabet && (w_btb_kosulsuz || w_yon);

    // Next-state values for counters, history and prediction outputs
    always_comb begin
        w_sayac_yeni = w_yazilan_sayac;
        if (g2_atladi_i) begin
            if (w_yazilan_sayac != c_SAYAC_UST) begin
                w_sayac_yeni = w_yazilan_sayac + 1'b1;
            end
        end else if (w_yazilan_sayac != '0) begin
            w_sayac_yeni = w_yazilan_sayac - 1'b1;
        end

        komit_ghr_d = komit_ghr_q;
        if (w_kosullu_egitim) begin
            komit_ghr_d = (komit_ghr_q << 1) | GECMIS_BIT'(g2_atladi_i);
        end

        // Recovery wins over any speculative shift in the same cycle
        spec_ghr_d = spec_ghr_q;
        if (w_kurtarma) begin
            spec_ghr_d = komit_ghr_d;
        end else if (w_istek && w_btb_isabet && !w_btb_kosulsuz) begin
            spec_ghr_d = (spec_ghr_q << 1) | GECMIS_BIT'(w_yon);
        end

        tahmin_gecerli_d = w_istek;
        tahmin_atladi_d  = w_istek && w_tahmin_atladi;
        tahmin_ps_d      = tahmin_atladi_d ? w_btb_hedef : '0;
    end

    // Pattern history table: trained by resolved conditional branches
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_PHT_SATIR; i++) begin
                pht_q[i] <= c_SAYAC_SIFIR;
            end
        end else if (w_kosullu_egitim) begin
            pht_q[w_yaz_idx] <= w_sayac_yeni;
        end
    end

    // Speculative and committed global history registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spec_ghr_q  <= '0;
            komit_ghr_q <= '0;
        end else begin
            spec_ghr_q  <= spec_ghr_d;
            komit_ghr_q <= komit_ghr_d;
        end
    end

    // Registered prediction outputs, one cycle after the request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tahmin_gecerli_q <= 1'b0;
            tahmin_atladi_q  <= 1'b0;
            tahmin_ps_q      <= '0;
        end else begin
            tahmin_gecerli_q <= tahmin_gecerli_d;
            tahmin_atladi_q  <= tahmin_atladi_d;
            tahmin_ps_q      <= tahmin_ps_d;
        end
    end

    assign g1_tahmin_gecerli_o = tahmin_gecerli_q;
    assign g1_tahmin_atladi_o  = tahmin_atladi_q;
    assign g1_tahmin_ps_o      = tahmin_ps_q;

endmodule
`default_nettype wire

// File: tb/tb_dallanma_ongorucu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dallanma_ongorucu
//  Description : Directed self-checking bench for the gshare/BTB predictor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dallanma_ongorucu;

    localparam int PS_BIT = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [PS_BIT-1:0] g1_ps;
    logic              g1_gecerli;
    logic              tahmin_gecerli;
    logic              tahmin_atladi;
    logic [PS_BIT-1:0] tahmin_ps;
    logic [PS_BIT-1:0] g2_ps;
    logic [PS_BIT-1:0] g2_hedef;
    logic              g2_guncelle;
    logic              g2_atladi;
    logic              g2_kosulsuz;
    logic              g2_hatali;

    int sayac_kontrol = 0;
    int sayac_hata    = 0;

    dallanma_ongorucu #(
        .PS_BIT     (PS_BIT),
        .BTB_SATIR  (16),
        .GECMIS_BIT (4),
        .SAYAC_BIT  (2)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .g1_ps_i             (g1_ps),
        .g1_ps_gecerli_i     (g1_gecerli),
        .g1_tahmin_gecerli_o (tahmin_gecerli),
        .g1_tahmin_atladi_o  (tahmin_atladi),
        .g1_tahmin_ps_o      (tahmin_ps),
        .g2_ps_i             (g2_ps),
        .g2_hedef_ps_i       (g2_hedef),
        .g2_guncelle_i       (g2_guncelle),
        .g2_atladi_i         (g2_atladi),
        .g2_kosulsuz_i       (g2_kosulsuz),
        .g2_hatali_tahmin_i  (g2_hatali)
    );

    always #5 clk = ~clk;

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                           input logic [63:0] beklenen);
        sayac_kontrol++;
        if (gozlenen !== beklenen) begin
            sayac_hata++;
            $display("FAIL %s: gozlenen=0x%0h beklenen=0x%0h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic cikis_kontrol(input string etiket, input logic gecerli,
                                 input logic atladi, input logic [PS_BIT-1:0] ps);
        kontrol({etiket, "_gecerli"}, 64'(tahmin_gecerli), 64'(gecerli));
        kontrol({etiket, "_atladi"},  64'(tahmin_atladi),  64'(atladi));
        kontrol({etiket, "_ps"},      64'(tahmin_ps),      64'(ps));
    endtask

    task automatic tik();
        @(posedge clk);
        #1;
    endtask

    task automatic bosalt();
        g1_ps       = '0;
        g1_gecerli  = 1'b0;
        g2_ps       = '0;
        g2_hedef    = '0;
        g2_guncelle = 1'b0;
        g2_atladi   = 1'b0;
        g2_kosulsuz = 1'b0;
        g2_hatali   = 1'b0;
    endtask

    task automatic g1_iste(input logic [PS_BIT-1:0] ps);
        g1_ps      = ps;
        g1_gecerli = 1'b1;
    endtask

    task automatic g2_ayarla(input logic [PS_BIT-1:0] ps, input logic [PS_BIT-1:0] hedef,
                             input logic atladi, input logic kosulsuz, input logic hatali);
        g2_ps       = ps;
        g2_hedef    = hedef;
        g2_guncelle = 1'b1;
        g2_atladi   = atladi;
        g2_kosulsuz = kosulsuz;
        g2_hatali   = hatali;
    endtask

    task automatic sifirla();
        rst = 1'b1;
        tik();
        tik();
        rst = 1'b0;
    endtask

    initial begin
        bosalt();
        #1 rst = 1'b1;
        #2;
        cikis_kontrol("sifirlama", 1'b0, 1'b0, '0);
        tik();
        tik();
        rst = 1'b0;

        // T1: cold lookup misses, idle cycle drops valid
        g1_iste(32'h0040_0000); tik(); bosalt();
        cikis_kontrol("t1_istek", 1'b1, 1'b0, '0);
        tik();
        kontrol("t1_bos_gecerli", 64'(tahmin_gecerli), 64'd0);

        // T2: unconditional allocation, then hit and tag-mismatch lookups
        g2_ayarla(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b1, 1'b0); tik(); bosalt();
        g1_iste(32'h0040_0010); tik(); bosalt();
        cikis_kontrol("t2_isabet", 1'b1, 1'b1, 32'h0040_0100);
        g1_iste(32'h0040_0030); tik(); bosalt();
        cikis_kontrol("t2_etiket_farki", 1'b1, 1'b0, '0);

        // T3: mispredicted taken branch; recovered history indexes PHT[1]=01
        g2_ayarla(32'h0040_0020, 32'h0040_0080, 1'b1, 1'b0, 1'b1); tik(); bosalt();
        g1_iste(32'h0040_0020); tik(); bosalt();
        cikis_kontrol("t3_kurtarma_sonrasi", 1'b1, 1'b0, '0);

        // T4: not-taken saturation at 00 and no allocation on not-taken
        sifirla();
        for (int i = 0; i < 3; i++) begin
            g2_ayarla(32'h0040_0040, 32'h0040_0200, 1'b0, 1'b0, 1'b0); tik();
        end
        bosalt();
        g2_ayarla(32'h0040_0060, 32'h0040_0300, 1'b0, 1'b1, 1'b0); tik(); bosalt();
        g1_iste(32'h0040_0060); tik(); bosalt();
        cikis_kontrol("t4_tahsis_yok", 1'b1, 1'b0, '0);
        g1_iste(32'h0040_0040); tik(); bosalt();
        cikis_kontrol("t4_iskalama", 1'b1, 1'b0, '0);
        // PHT[0]: 00 -> 01, komit 0001, spec stays 0000
        g2_ayarla(32'h0040_0040, 32'h0040_0200, 1'b1, 1'b0, 1'b0); tik(); bosalt();
        g1_iste(32'h0040_0040); tik(); bosalt();
        cikis_kontrol("t4_doyma", 1'b1, 1'b0, '0);

        // T5: request dropped during recovery; PHT[9] 01->00, komit=spec=0010
        g1_iste(32'h0040_0040);
        g2_ayarla(32'h0040_0050, '0, 1'b0, 1'b0, 1'b1); tik(); bosalt();
        cikis_kontrol("t5_istek_dusuruldu", 1'b0, 1'b0, '0);
        // Update index 0^0010=2: PHT[2] 01->10; spec not touched
        g2_ayarla(32'h0040_0040, 32'h0040_0200, 1'b1, 1'b0, 1'b0); tik(); bosalt();
        // Lookup index 0^spec(0010)=2 -> taken
        g1_iste(32'h0040_0040); tik(); bosalt();
        cikis_kontrol("t5_spec_esit_komit", 1'b1, 1'b1, 32'h0040_0200);

        // T6: asynchronous reset mid-operation
        #2 rst = 1'b1;
        #1;
        cikis_kontrol("t6_asenkron", 1'b0, 1'b0, '0);
        tik();
        rst = 1'b0;
        g1_iste(32'h0040_0010); tik(); bosalt();
        cikis_kontrol("t6_sifirlama_sonrasi", 1'b1, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", sayac_kontrol, sayac_hata);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dallanma_ongorucu.md
Name: dallanma_ongorucu

Overview:
Parametrised gshare direction predictor plus branch target buffer (BTB) at fetch stage G1.
Generalises the combinational branch unit (dallanma_birimi): prediction state persists across cycles, with speculative global history and recovery on misprediction.
Trained from the branch unit's G2 outputs (g2_ps/hedef/guncelle/atladi/hatali_tahmin).

Parameters:
PS_BIT, 32, program counter width.
BTB_SATIR, 16, BTB entries; power of two, >=2; direct-mapped.
GECMIS_BIT, 4, global history length; PHT has 2^GECMIS_BIT entries; 1..12.
SAYAC_BIT, 2, saturating counter width; >=2.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
g1_ps_i  in  PS_BIT  fetch PC to predict.
g1_ps_gecerli_i  in  1  lookup request.
g1_tahmin_gecerli_o  out  1  prediction valid (one cycle after request).
g1_tahmin_atladi_o  out  1  predicted taken.
g1_tahmin_ps_o  out  PS_BIT  predicted target; 0 when not predicted taken.
g2_ps_i  in  PS_BIT  PC of resolved branch/jump.
g2_hedef_ps_i  in  PS_BIT  resolved target.
g2_guncelle_i  in  1  resolved control-flow instruction this cycle.
g2_atladi_i  in  1  actual outcome taken.
g2_kosulsuz_i  in  1  JAL/JALR (unconditional).
g2_hatali_tahmin_i  in  1  misprediction; fetch is flushed.

Behaviour:
- Reset (async, immediate): all BTB valid bits 0; PHT counters = weakly not-taken (2^(SAYAC_BIT-1)-1, i.e. 01); spec_ghr = komit_ghr = 0; all outputs 0.
- BTB index = ps[log2(BTB_SATIR):1] (bit 1 kept for RVC); tag = ps[PS_BIT-1:log2(BTB_SATIR)+1]. Entry = {gecerli, etiket, hedef, kosulsuz}.
- PHT lookup index = ps[GECMIS_BIT:1] XOR spec_ghr. PHT update index = g2_ps[GECMIS_BIT:1] XOR komit_ghr (value before this cycle's update).
- Lookup latency: 1 cycle; outputs are registered.
  - On edge with g1_ps_gecerli_i=1 and g2_hatali_tahmin_i=0: tahmin_gecerli<=1; hit = valid && tag match.
  - atladi <= hit && (kosulsuz || counter MSB); ps <= hedef if atladi else 0.
  - Otherwise tahmin_gecerli<=0, atladi<=0, ps<=0.
- Speculative history: on the same edge, if hit && !kosulsuz, spec_ghr <= {spec_ghr[GECMIS_BIT-2:0], predicted direction}.
- Training on g2_guncelle_i=1:
  - Conditional branches (!kosulsuz): counter at the update index saturating +1 if atladi, else -1. Holds at 0 and at max.
  - komit_ghr <= {komit_ghr<<1 | atladi} for conditional branches only.
  - If atladi=1: BTB entry written (allocate/overwrite) with tag, hedef, kosulsuz.
  - If atladi=0: BTB left unchanged; no allocation on not-taken.
- Recovery: g2_hatali_tahmin_i=1 (qualified by g2_guncelle_i):
  - spec_ghr <= the new komit_ghr value, overriding any speculative shift that cycle.
  - A g1 request in the same cycle is dropped: next tahmin_gecerli=0.
- Same-cycle read/write to the same BTB/PHT entry: the lookup sees the old value (read-before-write).
- g2_hatali_tahmin_i without g2_guncelle_i: ignored.
- Reset mid-operation: all state cleared immediately; first valid prediction requires a request after reset deassertion.

Decomposition:
- Shared define header (alongside the DAL_* opcodes): reset counter value, counter width default, BTB entry field layout.
- One sub-module, dal_hedef_tablosu: BTB storage, tag compare, and write port.
- PHT, history registers, and output registers stay in the top module.

Test Plan:
Defaults PS_BIT=32, BTB_SATIR=16, GECMIS_BIT=4.
1. Reset, then request g1_ps=0x00400000 -> next cycle tahmin_gecerli=1, atladi=0, ps=0; the following idle cycle gives tahmin_gecerli=0.
2. Update g2_ps=0x00400010, hedef=0x00400100, kosulsuz=1, atladi=1; then request 0x00400010 -> atladi=1, ps=0x00400100. Request 0x00400030 (same index, different tag) -> atladi=0.
3. Conditional update g2_ps=0x00400020, hedef=0x00400080, atladi=1, hatali=1 -> PHT[0x0 XOR 0]=10, komit_ghr=spec_ghr=0001. Request 0x00400020 -> BTB hit, PHT[0x0 XOR 1]=01 -> atladi=0, ps=0; spec_ghr becomes 0010.
4. Three not-taken conditional updates on 0x00400040 -> counter saturates at 00, komit_ghr stays 0000, no BTB allocation. Request 0x00400040 -> atladi=0.
5. g1_ps_gecerli=1 with g2_guncelle=1, hatali=1, atladi=0, conditional, same cycle -> next tahmin_gecerli=0; spec_ghr equals komit_ghr.
6. Assert rst_i asynchronously while tahmin_gecerli=1 and atladi=1 -> outputs drop to 0 before the next clock edge; a repeat of test 2's request after reset gives atladi=0.
